// File: rtl/dac_spi_pkg.sv
// Shared definitions for the DAC serial write path (transmitter and receiver).
// Frame geometry defaults, sclk timing and FSM state encodings.
package dac_spi_pkg;

  localparam int FRAME_W_DEF = 16;
  localparam int DATA_W_DEF  = 14;
  localparam int SCLK_HALF   = 4;

  typedef enum logic [3:0] {
    RX_ARM   = 4'b0001,
    RX_IDLE  = 4'b0010,
    RX_SHIFT = 4'b0100,
    RX_CHECK = 4'b1000
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SYNC_PRE,
    TX_DATA,
    TX_SYNC_END
  } tx_state_t;

  function automatic logic [FRAME_W_DEF-1:0] frame_pack(
    input logic [FRAME_W_DEF-DATA_W_DEF-1:0] ctrl,
    input logic [DATA_W_DEF-1:0]             data
  );
    return {ctrl, data};
  endfunction

endpackage

// File: rtl/dac_spi_sync.sv
// Multi-stage input synchronizer, presets to 1 (idle level of sclk/sync_n).
// Ports: clk, rst_n (async low), d (async input), q (synchronized output).
import dac_spi_pkg::*;

module dac_spi_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '1;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/dac_spi_rx.sv
// DAC write-frame serial receiver: oversamples sclk/sync_n/mosi, rebuilds
// the frame, emits {rx_ctrl, rx_data} with rx_valid or a frame_err pulse.
// Ports: clk, rst_n, sclk, mosi, sync_n in; rx_data, rx_ctrl, rx_valid,
// frame_err, busy out; frame_cnt/err_cnt when DAC_SPI_RX_STATS_EN defined.
import dac_spi_pkg::*;

module dac_spi_rx #(
  parameter int FRAME_W     = FRAME_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sclk,
  input  logic                      mosi,
  input  logic                      sync_n,
  output logic [DATA_W-1:0]         rx_data,
  output logic [FRAME_W-DATA_W-1:0] rx_ctrl,
  output logic                      rx_valid,
  output logic                      frame_err,
  output logic                      busy
`ifdef DAC_SPI_RX_STATS_EN
  ,
  output logic [15:0]               frame_cnt,
  output logic [15:0]               err_cnt
`endif
);

  localparam int CNT_W = $clog2(FRAME_W + 2);
  localparam int FLUSH = SYNC_STAGES + 1;
  localparam int ARM_W = $clog2(FLUSH + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(FRAME_W + 1);
  localparam logic [ARM_W-1:0] ARM_END  = ARM_W'(FLUSH);

  logic sclk_s, sync_s, mosi_s;
  logic sclk_d, sync_d;
  logic sclk_fall, sync_fall, sync_rise;

  rx_state_t           state;
  logic [FRAME_W-1:0]  shift_reg;
  logic [CNT_W-1:0]    bit_cnt;
  logic [ARM_W-1:0]    arm_cnt;

  dac_spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (sclk),
    .q    (sclk_s)
  );

  dac_spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (sync_n),
    .q    (sync_s)
  );

  dac_spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (mosi),
    .q    (mosi_s)
  );

  assign sclk_fall = sclk_d & ~sclk_s;
  assign sync_fall = sync_d & ~sync_s;
  assign sync_rise = ~sync_d & sync_s;

  assign busy = (state == RX_SHIFT) || (state == RX_CHECK);

  // ARM first lets the synchronizers flush their preset 1s, so a
  // sync_n held low through reset never looks like a frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RX_ARM;
      arm_cnt   <= '0;
      shift_reg <= '0;
      bit_cnt   <= '0;
      rx_data   <= '0;
      rx_ctrl   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      sclk_d    <= 1'b1;
      sync_d    <= 1'b1;
    end else begin
      sclk_d    <= sclk_s;
      sync_d    <= sync_s;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        RX_ARM: begin
          if (arm_cnt != ARM_END)
            arm_cnt <= arm_cnt + 1'b1;
          else if (sync_s && sync_d)
            state <= RX_IDLE;
        end
        RX_IDLE: begin
          if (sync_fall) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            state     <= RX_SHIFT;
          end
        end
        RX_SHIFT: begin
          if (sclk_fall) begin
            shift_reg <= {shift_reg[FRAME_W-2:0], mosi_s};
            if (bit_cnt != CNT_OVER)
              bit_cnt <= bit_cnt + 1'b1;
          end
          if (sync_rise)
            state <= RX_CHECK;
        end
        RX_CHECK: begin
          if (bit_cnt == CNT_FULL) begin
            rx_data  <= shift_reg[DATA_W-1:0];
            rx_ctrl  <= shift_reg[FRAME_W-1:DATA_W];
            rx_valid <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
          state <= RX_IDLE;
        end
        default: state <= RX_ARM;
      endcase
    end
  end

`ifdef DAC_SPI_RX_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (rx_valid && frame_cnt != 16'hFFFF)
        frame_cnt <= frame_cnt + 16'd1;
      if (frame_err && err_cnt != 16'hFFFF)
        err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dac_spi_rx.sv
// Self-checking bench for dac_spi_rx: bit-banged frames, scoreboard of
// expected payloads/errors, reset and framing corner cases.
`timescale 1ns/1ps
import dac_spi_pkg::*;

module tb_dac_spi_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b1;
  logic        mosi = 1'b0;
  logic        sync_n = 1'b1;
  logic [13:0] rx_data;
  logic [1:0]  rx_ctrl;
  logic        rx_valid;
  logic        frame_err;
  logic        busy;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;

  int checks = 0;
  int failures = 0;
  int valid_seen = 0;
  int err_seen = 0;
  int err_exp = 0;
  logic [15:0] sb[$];

  always #5 clk = ~clk;

  dac_spi_rx u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sclk     (sclk),
    .mosi     (mosi),
    .sync_n   (sync_n),
    .rx_data  (rx_data),
    .rx_ctrl  (rx_ctrl),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
`ifdef DAC_SPI_RX_STATS_EN
    ,
    .frame_cnt(frame_cnt),
    .err_cnt  (err_cnt)
`endif
  );

`ifndef DAC_SPI_RX_STATS_EN
  assign frame_cnt = '0;
  assign err_cnt   = '0;
`endif

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        logic [15:0] exp;
        valid_seen++;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_valid got=%h", {rx_ctrl, rx_data});
        end else begin
          exp = sb.pop_front();
          if ({rx_ctrl, rx_data} !== exp) begin
            failures++;
            $display("FAIL rx_word got=%h exp=%h",
                     {rx_ctrl, rx_data}, exp);
          end
        end
      end
      if (frame_err) begin
        err_seen++;
        checks++;
        if (err_exp == 0) begin
          failures++;
          $display("FAIL unexpected_err got=1 exp=0");
        end else begin
          err_exp--;
        end
      end
    end
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame_body(input logic [15:0] w, input int nbits,
                            input int half);
    sync_n = 1'b0;
    clks(half);
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 16) ? w[15-i] : 1'b0;
      clks(half);
      sclk = 1'b0;
      clks(half);
      sclk = 1'b1;
    end
    clks(half);
  endtask

  task automatic send_frame(input logic [15:0] w, input int nbits,
                            input int half);
    frame_body(w, nbits, half);
    sync_n = 1'b1;
    clks(3);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 300 && (sb.size() != 0 || err_exp != 0); i++)
      @(negedge clk);
    checks++;
    if (sb.size() != 0 || err_exp != 0) begin
      failures++;
      $display("FAIL %s_timeout pend_valid=%0d pend_err=%0d exp=0",
               name, sb.size(), err_exp);
      sb.delete();
      err_exp = 0;
    end
    clks(2);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    clks(3);
    #1;
    checks++;
    if ({rx_valid, frame_err, busy} !== 3'b000) begin
      failures++;
      $display("FAIL reset_pulses got=%b exp=000",
               {rx_valid, frame_err, busy});
    end
    checks++;
    if ({rx_ctrl, rx_data} !== 16'h0000) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0000", {rx_ctrl, rx_data});
    end
    checks++;
    if (u_dut.state !== RX_ARM) begin
      failures++;
      $display("FAIL reset_state got=%b exp=%b", u_dut.state, RX_ARM);
    end
    rst_n = 1'b1;
    clks(10);
  endtask

  task automatic test_tx_write;
    int lat;
    sb.push_back(frame_pack(2'b00, 14'h2A5C));
    sync_n = 1'b0;
    clks(SCLK_HALF);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL tx_busy got=%b exp=1", busy);
    end
    for (int i = 0; i < 16; i++) begin
      mosi = frame_pack(2'b00, 14'h2A5C) >> (15 - i);
      clks(SCLK_HALF);
      sclk = 1'b0;
      clks(SCLK_HALF);
      sclk = 1'b1;
    end
    clks(SCLK_HALF);
    sync_n = 1'b1;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (rx_valid) break;
    end
    checks++;
    if (lat != 4) begin
      failures++;
      $display("FAIL tx_latency got=%0d exp=4", lat);
    end
    wait_drain("tx_write");
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL tx_idle_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_all_ones;
    sb.push_back(16'hFFFF);
    send_frame(16'hFFFF, 16, 4);
    wait_drain("all_ones");
    checks++;
    if (rx_ctrl !== 2'b11 || rx_data !== 14'h3FFF) begin
      failures++;
      $display("FAIL all_ones_hold got=%h exp=ffff", {rx_ctrl, rx_data});
    end
  endtask

  task automatic test_short;
    int v0;
    v0 = valid_seen;
    err_exp++;
    send_frame(16'h1234, 9, 3);
    wait_drain("short");
    checks++;
    if ({rx_ctrl, rx_data} !== 16'hFFFF) begin
      failures++;
      $display("FAIL short_hold got=%h exp=ffff", {rx_ctrl, rx_data});
    end
    checks++;
    if (valid_seen != v0) begin
      failures++;
      $display("FAIL short_valid got=%0d exp=%0d", valid_seen, v0);
    end
  endtask

  task automatic test_long;
    err_exp++;
    send_frame(16'hA5A5, 17, 3);
    wait_drain("long_err");
    checks++;
    if ({rx_ctrl, rx_data} !== 16'hFFFF) begin
      failures++;
      $display("FAIL long_hold got=%h exp=ffff", {rx_ctrl, rx_data});
    end
    sb.push_back(16'h0001);
    send_frame(16'h0001, 16, 3);
    wait_drain("long_next");
    checks++;
    if (rx_data !== 14'h0001) begin
      failures++;
      $display("FAIL long_next_data got=%h exp=0001", rx_data);
    end
  endtask

  task automatic test_stats;
`ifdef DAC_SPI_RX_STATS_EN
    checks++;
    if (frame_cnt !== 16'd3 || err_cnt !== 16'd2) begin
      failures++;
      $display("FAIL stats got=%0d/%0d exp=3/2", frame_cnt, err_cnt);
    end
`endif
  endtask

  task automatic test_simul;
    sb.push_back(16'h5A3C);
    sync_n = 1'b0;
    clks(3);
    for (int i = 0; i < 16; i++) begin
      mosi = 16'h5A3C >> (15 - i);
      clks(3);
      sclk = 1'b0;
      if (i == 15) sync_n = 1'b1;
      clks(3);
      sclk = 1'b1;
    end
    wait_drain("simul");
  endtask

  task automatic test_back_to_back;
    logic [15:0] w;
    for (int k = 0; k < 3; k++) begin
      w = 16'($urandom);
      sb.push_back(w);
      frame_body(w, 16, 2);
      sync_n = 1'b1;
      clks(2);
    end
    wait_drain("b2b");
  endtask

  task automatic test_reset_low_sync;
    int v0, e0;
    rst_n = 1'b0;
    sync_n = 1'b0;
    clks(3);
    rst_n = 1'b1;
    clks(2);
    v0 = valid_seen;
    e0 = err_seen;
    mosi = 1'b1;
    for (int i = 0; i < 4; i++) begin
      clks(4);
      sclk = 1'b0;
      clks(4);
      sclk = 1'b1;
    end
    clks(4);
    sync_n = 1'b1;
    clks(12);
    checks++;
    if (valid_seen != v0 || err_seen != e0) begin
      failures++;
      $display("FAIL lowsync_pulses got=%0d/%0d exp=%0d/%0d",
               valid_seen, err_seen, v0, e0);
    end
    checks++;
    if ({rx_ctrl, rx_data} !== 16'h0000) begin
      failures++;
      $display("FAIL lowsync_data got=%h exp=0000", {rx_ctrl, rx_data});
    end
    sb.push_back(16'h8123);
    send_frame(16'h8123, 16, 4);
    wait_drain("lowsync_good");
    checks++;
    if (rx_ctrl !== 2'b10 || rx_data !== 14'h0123) begin
      failures++;
      $display("FAIL lowsync_good got=%h exp=8123", {rx_ctrl, rx_data});
    end
  endtask

  task automatic test_mid_reset;
    int v0, e0;
    v0 = valid_seen;
    e0 = err_seen;
    frame_body(16'hC3C3, 8, 3);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rx_valid, frame_err, busy} !== 3'b000 ||
        {rx_ctrl, rx_data} !== 16'h0000) begin
      failures++;
      $display("FAIL midrst_out got=%b/%h exp=000/0000",
               {rx_valid, frame_err, busy}, {rx_ctrl, rx_data});
    end
    checks++;
    if (u_dut.state !== RX_ARM) begin
      failures++;
      $display("FAIL midrst_state got=%b exp=%b", u_dut.state, RX_ARM);
    end
    clks(3);
    rst_n = 1'b1;
    clks(12);
    sync_n = 1'b1;
    clks(12);
    checks++;
    if (valid_seen != v0 || err_seen != e0) begin
      failures++;
      $display("FAIL midrst_pulses got=%0d/%0d exp=%0d/%0d",
               valid_seen, err_seen, v0, e0);
    end
    sb.push_back(16'h4C3C);
    send_frame(16'h4C3C, 16, 3);
    wait_drain("midrst_good");
  endtask

  initial begin
    test_reset();
    test_tx_write();
    test_all_ones();
    test_short();
    test_long();
    test_stats();
    test_simul();
    test_back_to_back();
    test_reset_low_sync();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
